// File: rtl/mem_arbiter.sv
// N-channel memory arbiter: multiplexes CPU-side requesters onto one device port
// with fixed-priority or round-robin grant, a busy watchdog and per-channel completion.
module mem_arbiter #(
    parameter int NCHAN      = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int RR_MODE    = 1,
    parameter int TIMEOUT    = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NCHAN-1:0]              chan_req,
    input  logic [NCHAN*ADDR_WIDTH-1:0]   chan_addr,
    input  logic [NCHAN-1:0]              chan_is_write,
    input  logic [NCHAN*DATA_WIDTH-1:0]   chan_data_in,
    output logic [DATA_WIDTH-1:0]         chan_data_out,
    output logic [NCHAN-1:0]              chan_grant,
    output logic [NCHAN-1:0]              chan_done,
    output logic                          chan_err,
    output logic                          dev_mem_en,
    output logic [ADDR_WIDTH-1:0]         dev_mem_addr,
    output logic [DATA_WIDTH-1:0]         dev_mem_data_out,
    input  logic [DATA_WIDTH-1:0]         dev_mem_data_in,
    output logic                          dev_mem_is_write,
    input  logic                          dev_mem_busy
);

    localparam int IDXW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                state;
    state_t                next_state;
    logic [IDXW-1:0]       last_grant;
    logic [15:0]           wdog;
    logic                  any_req;
    logic                  timed_out;
    logic                  access_end;
    logic                  found_hi;
    logic                  found_lo;
    int                    win_hi;
    int                    win_lo;
    int                    win;
    logic [NCHAN-1:0]      win_onehot;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_wr;

    assign any_req    = |chan_req;
    assign timed_out  = dev_mem_busy && (wdog == 16'(TIMEOUT));
    assign access_end = !dev_mem_busy || timed_out;

    // Round-robin picks the lowest requester above last_grant, else wraps to the lowest overall.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        win_hi   = 0;
        win_lo   = 0;
        for (int i = 0; i < NCHAN; i++) begin
            if (chan_req[i] && !found_lo) begin
                found_lo = 1'b1;
                win_lo   = i;
            end
            if (chan_req[i] && !found_hi && (i > int'(last_grant))) begin
                found_hi = 1'b1;
                win_hi   = i;
            end
        end
        win = ((RR_MODE != 0) && found_hi) ? win_hi : win_lo;

        win_onehot = '0;
        sel_addr   = '0;
        sel_data   = '0;
        sel_wr     = 1'b0;
        for (int i = 0; i < NCHAN; i++) begin
            if (i == win) begin
                win_onehot[i] = 1'b1;
                sel_addr      = chan_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data      = chan_data_in[i*DATA_WIDTH +: DATA_WIDTH];
                sel_wr        = chan_is_write[i];
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (any_req) next_state = ACCESS;
            ACCESS:  if (access_end) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            last_grant       <= IDXW'(NCHAN - 1);
            wdog             <= '0;
            chan_data_out    <= '0;
            chan_grant       <= '0;
            chan_done        <= '0;
            chan_err         <= 1'b0;
            dev_mem_en       <= 1'b0;
            dev_mem_addr     <= '0;
            dev_mem_data_out <= '0;
            dev_mem_is_write <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        chan_grant       <= win_onehot;
                        last_grant       <= IDXW'(win);
                        dev_mem_addr     <= sel_addr;
                        dev_mem_data_out <= sel_data;
                        dev_mem_is_write <= sel_wr;
                        dev_mem_en       <= 1'b1;
                        wdog             <= '0;
                    end
                end
                ACCESS: begin
                    if (!dev_mem_busy) begin
                        if (!dev_mem_is_write) chan_data_out <= dev_mem_data_in;
                        dev_mem_en <= 1'b0;
                        chan_done  <= chan_grant;
                        chan_err   <= 1'b0;
                    end else if (timed_out) begin
                        dev_mem_en <= 1'b0;
                        chan_done  <= chan_grant;
                        chan_err   <= 1'b1;
                    end else begin
                        wdog <= wdog + 16'd1;
                    end
                end
                DONE: begin
                    chan_done  <= '0;
                    chan_err   <= 1'b0;
                    chan_grant <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
